// File: rtl/hs_fifo_arb_if.sv
// ============================================================================
// Module      : hs_fifo_arb_if
// Description : Bundled requester, shared-FIFO and response signals of hs_fifo_arb.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface hs_fifo_arb_if #(
  parameter int NREQ    = 4,
  parameter int DATA_WD = 4,
  parameter int ADDR_WD = 4
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_cmd;
  logic [NREQ*ADDR_WD-1:0] req_addr;
  logic [NREQ*DATA_WD-1:0] req_data;
  logic [NREQ-1:0]         req_ready;

  logic                    m_valid;
  logic                    m_cmd;
  logic [ADDR_WD-1:0]      m_addr;
  logic [DATA_WD-1:0]      m_data;
  logic                    m_ready;

  logic                    s_valid;
  logic [DATA_WD-1:0]      s_data;
  logic                    s_ready;

  logic [NREQ-1:0]         rsp_valid;
  logic [DATA_WD-1:0]      rsp_data;
  logic [NREQ-1:0]         rsp_ready;

  modport slave (
    input  req_valid, req_cmd, req_addr, req_data, m_ready, s_valid, s_data, rsp_ready,
    output req_ready, m_valid, m_cmd, m_addr, m_data, s_ready, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_cmd, req_addr, req_data, m_ready, s_valid, s_data, rsp_ready,
    input  req_ready, m_valid, m_cmd, m_addr, m_data, s_ready, rsp_valid, rsp_data
  );
endinterface

`default_nettype wire

// File: rtl/hs_fifo_arb.sv
// ============================================================================
// Module      : hs_fifo_arb
// Description : Round-robin arbiter sharing one handshake FIFO port, with an
//               in-order tag queue routing read data back to its requester.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hs_fifo_arb #(
  parameter int NREQ      = 4,
  parameter int DATA_WD   = 4,
  parameter int ADDR_WD   = 4,
  parameter int TAG_DEPTH = 4
) (
  input  wire logic     clk,
  input  wire logic     rstn,
  hs_fifo_arb_if.slave  bus
);

  localparam int c_IDW = $clog2(NREQ);
  localparam int c_TAW = $clog2(TAG_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_IDW-1:0]   r_rr_ptr;
  logic [c_IDW-1:0]   r_lock_id;
  logic [c_TAW:0]     r_wptr;
  logic [c_TAW:0]     r_rptr;
  logic [c_IDW-1:0]   r_tag_mem [TAG_DEPTH];

  logic               w_tag_full;
  logic               w_tag_empty;
  logic [NREQ-1:0]    w_elig;
  logic               w_found;
  logic [c_IDW-1:0]   w_win;
  logic [c_IDW-1:0]   w_idx;
  logic [c_IDW-1:0]   w_gnt;
  logic [c_IDW-1:0]   w_head;
  logic               w_fire;
  logic               w_push;
  logic               w_pop;

  // Full/empty come from registered pointers only, so a same-cycle pop never unblocks a read.
  assign w_tag_empty = (r_wptr == r_rptr);
  assign w_tag_full  = (r_wptr[c_TAW] != r_rptr[c_TAW]) &&
                       (r_wptr[c_TAW-1:0] == r_rptr[c_TAW-1:0]);
  assign w_elig      = bus.req_valid & (bus.req_cmd | {NREQ{~w_tag_full}});

  // Scan downward so the last hit written is the first eligible index at/after r_rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = c_IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_gnt        = (r_state == ST_LOCK) ? r_lock_id : w_win;
  assign bus.m_valid  = (r_state == ST_LOCK) || w_found;
  assign bus.m_cmd    = bus.req_cmd[w_gnt];
  assign bus.m_addr   = bus.req_addr[w_gnt*ADDR_WD +: ADDR_WD];
  assign bus.m_data   = bus.req_data[w_gnt*DATA_WD +: DATA_WD];

  always_comb begin
    bus.req_ready        = '0;
    bus.req_ready[w_gnt] = bus.m_valid && bus.m_ready;
  end

  assign w_fire = bus.m_valid && bus.m_ready;
  assign w_push = w_fire && !bus.m_cmd;
  assign w_head = r_tag_mem[r_rptr[c_TAW-1:0]];

  assign bus.s_ready  = !w_tag_empty && bus.rsp_ready[w_head];
  assign bus.rsp_data = bus.s_data;
  assign w_pop        = bus.s_valid && bus.s_ready;

  always_comb begin
    bus.rsp_valid         = '0;
    bus.rsp_valid[w_head] = bus.s_valid && !w_tag_empty;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.m_valid && !bus.m_ready) begin
            r_state   <= ST_LOCK;
            r_lock_id <= w_win;
          end
        end
        ST_LOCK: begin
          if (bus.m_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_fire) begin
        r_rr_ptr <= (w_gnt == c_IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wptr[c_TAW-1:0]] <= w_gnt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hs_fifo_arb.sv
// ============================================================================
// Module      : tb_hs_fifo_arb
// Description : Directed self-checking bench for hs_fifo_arb.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_hs_fifo_arb;

  localparam int c_NREQ = 4;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  hs_fifo_arb_if #(.NREQ(4), .DATA_WD(4), .ADDR_WD(4)) bus ();

  hs_fifo_arb #(
    .NREQ      (4),
    .DATA_WD   (4),
    .ADDR_WD   (4),
    .TAG_DEPTH (4)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_cmd   = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
  endtask

  task automatic drive(input int i, input logic cmd, input logic [3:0] addr, input logic [3:0] data);
    bus.req_valid[i]      = 1'b1;
    bus.req_cmd[i]        = cmd;
    bus.req_addr[i*4 +: 4] = addr;
    bus.req_data[i*4 +: 4] = data;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_m_valid"},   32'(bus.m_valid),   32'h0);
    check_val({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
    check_val({tag, "_s_ready"},   32'(bus.s_ready),   32'h0);
    check_val({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
  endtask

  int rd_ids [4] = '{1, 3, 1, 0};

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn     = 1'b0;
    clear_reqs();
    bus.m_ready   = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.rsp_ready = '0;

    repeat (2) @(posedge clk);
    #1;
    check_quiet("rst_hold");
    rstn = 1'b1;
    #1;
    check_quiet("rst_post");
    bus.s_valid   = 1'b1;
    bus.rsp_ready = 4'hF;
    #1;
    check_val("rst_empty_s_ready",   32'(bus.s_ready),   32'h0);
    check_val("rst_empty_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    bus.s_valid = 1'b0;
    tick();

    // All four requesters write continuously: grants rotate and wrap.
    for (int i = 0; i < c_NREQ; i++) drive(i, 1'b1, 4'(8 + i), 4'(i + 1));
    bus.m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_val($sformatf("rr_grant%0d", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
      check_val($sformatf("rr_data%0d", k),  32'(bus.m_data),    32'((k % 4) + 1));
      check_val($sformatf("rr_addr%0d", k),  32'(bus.m_addr),    32'(8 + (k % 4)));
      tick();
    end
    clear_reqs();

    // Move the pointer to 0 so requester 0 would win if the lock were ignored.
    drive(3, 1'b1, 4'h3, 4'h9);
    #1;
    check_val("rr_solo3", 32'(bus.req_ready), 32'h8);
    tick();
    clear_reqs();

    bus.m_ready = 1'b0;
    drive(2, 1'b1, 4'hA, 4'h6);
    #1;
    check_val("lock_m_valid", 32'(bus.m_valid),   32'h1);
    check_val("lock_rdy0",    32'(bus.req_ready), 32'h0);
    check_val("lock_addr0",   32'(bus.m_addr),    32'hA);
    tick();
    drive(0, 1'b1, 4'h1, 4'h7);
    for (int k = 1; k < 3; k++) begin
      #1;
      check_val($sformatf("lock_addr%0d", k), 32'(bus.m_addr), 32'hA);
      check_val($sformatf("lock_data%0d", k), 32'(bus.m_data), 32'h6);
      tick();
    end
    bus.m_ready = 1'b1;
    #1;
    check_val("lock_release", 32'(bus.req_ready), 32'h4);
    tick();
    #1;
    check_val("lock_next_grant", 32'(bus.req_ready), 32'h1);
    check_val("lock_next_addr",  32'(bus.m_addr),    32'h1);
    tick();
    clear_reqs();

    // Fill the tag queue with reads from 1,3,1,0.
    for (int k = 0; k < 4; k++) begin
      drive(rd_ids[k], 1'b0, 4'(rd_ids[k]), 4'h0);
      #1;
      check_val($sformatf("fill_rd%0d", k), 32'(bus.req_ready), 32'(1 << rd_ids[k]));
      tick();
      clear_reqs();
    end
    drive(2, 1'b0, 4'h2, 4'h0);
    drive(0, 1'b1, 4'h5, 4'hE);
    #1;
    check_val("full_write_ok", 32'(bus.req_ready), 32'h1);
    check_val("full_write_cmd", 32'(bus.m_cmd),    32'h1);
    check_val("full_write_dat", 32'(bus.m_data),   32'hE);
    tick();
    bus.req_valid[0] = 1'b0;
    #1;
    check_val("full_rd_block_v", 32'(bus.m_valid),   32'h0);
    check_val("full_rd_block_r", 32'(bus.req_ready), 32'h0);
    tick();
    bus.s_valid   = 1'b1;
    bus.s_data    = 4'hA;
    bus.rsp_ready = 4'hF;
    #1;
    check_val("pop_rsp_valid",   32'(bus.rsp_valid), 32'h2);
    check_val("pop_rsp_data",    32'(bus.rsp_data),  32'hA);
    check_val("pop_s_ready",     32'(bus.s_ready),   32'h1);
    check_val("pop_rd_blocked",  32'(bus.req_ready), 32'h0);
    tick();
    bus.s_valid = 1'b0;
    #1;
    check_val("rd_after_pop", 32'(bus.req_ready), 32'h4);
    tick();
    clear_reqs();

    // Queue now holds 3,1,0,2; stall requester 3's response for two cycles.
    bus.s_valid   = 1'b1;
    bus.s_data    = 4'hB;
    bus.rsp_ready = 4'h7;
    for (int k = 0; k < 2; k++) begin
      #1;
      check_val($sformatf("stall_valid%0d", k), 32'(bus.rsp_valid), 32'h8);
      check_val($sformatf("stall_sready%0d", k), 32'(bus.s_ready),  32'h0);
      check_val($sformatf("stall_data%0d", k),  32'(bus.rsp_data),  32'hB);
      tick();
    end
    bus.rsp_ready = 4'hF;
    #1;
    check_val("stall_release", 32'(bus.s_ready), 32'h1);
    tick();
    bus.s_data = 4'hC;
    #1;
    check_val("order_c", 32'(bus.rsp_valid), 32'h2);
    tick();
    bus.s_data = 4'hD;
    #1;
    check_val("order_d", 32'(bus.rsp_valid), 32'h1);
    tick();
    bus.s_valid = 1'b0;

    // Occupancy 1 (tag 2); add tag 1 then push 3 while popping 2.
    drive(1, 1'b0, 4'h1, 4'h0);
    #1;
    check_val("pp_rd1", 32'(bus.req_ready), 32'h2);
    tick();
    clear_reqs();
    drive(3, 1'b0, 4'h3, 4'h0);
    bus.s_valid = 1'b1;
    bus.s_data  = 4'h5;
    #1;
    check_val("pp_push", 32'(bus.req_ready), 32'h8);
    check_val("pp_pop",  32'(bus.rsp_valid), 32'h4);
    check_val("pp_srdy", 32'(bus.s_ready),   32'h1);
    tick();
    clear_reqs();
    bus.s_data = 4'h6;
    #1;
    check_val("pp_order1", 32'(bus.rsp_valid), 32'h2);
    tick();
    bus.s_data = 4'h7;
    #1;
    check_val("pp_order3", 32'(bus.rsp_valid), 32'h8);
    tick();

    // Empty queue: a response in the same cycle as its read fire is not routed.
    bus.s_data = 4'h8;
    drive(0, 1'b0, 4'h0, 4'h0);
    #1;
    check_val("same_cyc_fire",  32'(bus.req_ready), 32'h1);
    check_val("same_cyc_srdy",  32'(bus.s_ready),   32'h0);
    check_val("same_cyc_rspv",  32'(bus.rsp_valid), 32'h0);
    tick();
    clear_reqs();
    #1;
    check_val("next_cyc_rspv", 32'(bus.rsp_valid), 32'h1);
    check_val("next_cyc_data", 32'(bus.rsp_data),  32'h8);
    tick();
    bus.s_valid = 1'b0;

    // Reset mid-burst with two reads outstanding.
    drive(1, 1'b0, 4'h1, 4'h0);
    #1;
    check_val("mid_rd1", 32'(bus.req_ready), 32'h2);
    tick();
    clear_reqs();
    drive(2, 1'b0, 4'h2, 4'h0);
    #1;
    check_val("mid_rd2", 32'(bus.req_ready), 32'h4);
    tick();
    clear_reqs();
    bus.m_ready   = 1'b0;
    bus.rsp_ready = '0;
    #2;
    rstn = 1'b0;
    #1;
    check_quiet("mid_rst");
    tick();
    rstn          = 1'b1;
    bus.s_valid   = 1'b1;
    bus.rsp_ready = 4'hF;
    #1;
    check_val("mid_rst_srdy", 32'(bus.s_ready),   32'h0);
    check_val("mid_rst_rspv", 32'(bus.rsp_valid), 32'h0);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    drive(2, 1'b1, 4'h2, 4'h0);
    drive(3, 1'b1, 4'h3, 4'h0);
    #1;
    check_val("mid_rst_ptr", 32'(bus.req_ready), 32'h4);
    tick();
    clear_reqs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
